// File: rtl/gcd_if.sv
// Handshake and shared adder/subtractor bundle for gcd_sequencer.
// The slave modport is the sequencer side; the master modport is the requester/unit side.
interface gcd_if;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       err;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_mod;
  logic       alu_cin;
  logic [7:0] alu_s;
  logic       alu_cout;

  modport slave (
    input  start, a_in, b_in, alu_s, alu_cout,
    output busy, done, result, err, alu_a, alu_b, alu_mod, alu_cin
  );

  modport master (
    output start, a_in, b_in, alu_s, alu_cout,
    input  busy, done, result, err, alu_a, alu_b, alu_mod, alu_cin
  );
endinterface

// File: rtl/gcd_sequencer.sv
// Subtraction-based Euclid GCD controller driving a shared 8-bit adder/subtractor.
// Optional RUN-cycle abort is built only when GCD_TIMEOUT_EN is defined (limit = TIMEOUT).
module gcd_sequencer
`ifdef GCD_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 300
)
`endif
(
  input  logic    clk,
  input  logic    rst,
  gcd_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       err_q, err_d;

`ifdef GCD_TIMEOUT_EN
  logic [8:0] cnt_q, cnt_d;
  logic       timeout_hit;

  assign timeout_hit = (cnt_q == 9'(TIMEOUT - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 9'd0;
    else     cnt_q <= cnt_d;
  end
`endif

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef GCD_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a_in;
          b_d   = bus.b_in;
          err_d = 1'b0;
          if (bus.a_in == 8'h00 && bus.b_in == 8'h00) begin
            result_d = 8'h00;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else if (bus.a_in == 8'h00) begin
            result_d = bus.b_in;
            state_d  = S_DONE;
          end else if (bus.b_in == 8'h00) begin
            result_d = bus.a_in;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
`ifdef GCD_TIMEOUT_EN
            cnt_d   = 9'd0;
`endif
          end
        end
      end

      S_RUN: begin
`ifdef GCD_TIMEOUT_EN
        cnt_d = cnt_q + 9'd1;
`endif
        // A zero difference means A == B, which is the GCD.
        if (bus.alu_s == 8'h00) begin
          result_d = a_q;
          state_d  = S_DONE;
`ifdef GCD_TIMEOUT_EN
        end else if (timeout_hit) begin
          result_d = 8'h00;
          err_d    = 1'b1;
          state_d  = S_DONE;
`endif
        end else if (bus.alu_cout) begin
          a_d = bus.alu_s;
        end else begin
          // Borrow: A < B, so swap to keep the subtraction non-negative.
          a_d = b_q;
          b_d = a_q;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.result  = result_q;
  assign bus.err     = err_q;
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  // The shared unit is only claimed while iterating.
  assign bus.alu_mod = (state_q == S_RUN);
  assign bus.alu_cin = (state_q == S_RUN);

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed, scoreboard-based bench for gcd_sequencer with a behavioural adder/subtractor.
// Timeout scenarios are included when GCD_TIMEOUT_EN is defined.
module tb_gcd_sequencer;

  logic clk;
  logic rst;
  logic stuck;
  int   errors;
  int   checks;

  gcd_if bus ();

`ifdef GCD_TIMEOUT_EN
  gcd_sequencer #(.TIMEOUT(257)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  gcd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared unit: A + (mod ? ~B : B) + cin, optionally stuck.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a}
            + (bus.alu_mod ? {1'b0, ~bus.alu_b} : {1'b0, bus.alu_b})
            + {8'd0, bus.alu_cin};
    bus.alu_s    = stuck ? 8'h01 : alu_sum[7:0];
    bus.alu_cout = stuck ? 1'b1  : alu_sum[8];
  end

  typedef struct {
    logic [7:0] result;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of RUN cycles for nonzero operands: subtracts + swaps + final zero detect.
  function automatic int run_cycles(input logic [7:0] a, input logic [7:0] b);
    int n;
    int x, y, t;
    n = 0;
    x = int'(a);
    y = int'(b);
    while (1) begin
      n++;
      if (x == y) break;
      if (x > y) x = x - y;
      else begin t = x; x = y; y = t; end
    end
    return n;
  endfunction

  function automatic exp_t expect_for(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (a == 8'd0 && b == 8'd0) begin e.result = 8'd0; e.err = 1'b1; e.lat = 1; end
    else if (a == 8'd0)         begin e.result = b;    e.err = 1'b0; e.lat = 1; end
    else if (b == 8'd0)         begin e.result = a;    e.err = 1'b0; e.lat = 1; end
    else begin
      e.result = gcd_ref(a, b);
      e.err    = 1'b0;
      e.lat    = run_cycles(a, b) + 1;
    end
    return e;
  endfunction

  // Present start for the accepting edge; start stays high when hold is set.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit hold, input exp_t e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, compare against the scoreboard head, then check the pulse ends.
  task automatic finish_op(input string tag, output int lat);
    exp_t e;
    int   k;
    bit   seen;
    k    = 0;
    seen = 1'b0;
    e.result = 8'hxx;
    e.err    = 1'bx;
    e.lat    = -1;
    if (sb.size() > 0) e = sb[0];
    while (!seen && k < 600) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, " busy_c1"}, 32'(bus.busy), 32'(1));
        check({tag, " alu_mod_c1"}, 32'(bus.alu_mod), 32'(e.lat > 1));
      end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    lat = k;
    check({tag, " done_seen"}, 32'(seen), 32'(1));
    check({tag, " sb_size"}, 32'(sb.size()), 32'(1));
    if (sb.size() > 0) void'(sb.pop_front());
    check({tag, " result"}, 32'(bus.result), 32'(e.result));
    check({tag, " err"}, 32'(bus.err), 32'(e.err));
    check({tag, " done_cycle"}, 32'(k), 32'(e.lat));
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(bus.done), 32'(0));
    check({tag, " idle_busy"}, 32'(bus.busy), 32'(0));
    check({tag, " result_held"}, 32'(bus.result), 32'(e.result));
  endtask

  initial begin
    int   lat;
    bit   spurious;
    exp_t e;

    errors    = 0;
    checks    = 0;
    stuck     = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = 8'h00;
    bus.b_in  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'(0));
    check("rst done", 32'(bus.done), 32'(0));
    check("rst result", 32'(bus.result), 32'(0));
    check("rst err", 32'(bus.err), 32'(0));
    check("rst alu_a", 32'(bus.alu_a), 32'(0));
    check("rst alu_b", 32'(bus.alu_b), 32'(0));
    check("rst alu_mod", 32'(bus.alu_mod), 32'(0));
    check("rst alu_cin", 32'(bus.alu_cin), 32'(0));
    rst = 1'b0;

    // (12,8): 4 RUN cycles, done in cycle 5
    launch(8'd12, 8'd8, 1'b0, expect_for(8'd12, 8'd8));
    finish_op("g12_8", lat);
    check("g12_8 lat_const", 32'(lat), 32'(5));

    // (1,255): worst case, 256 RUN cycles
    launch(8'd1, 8'd255, 1'b0, expect_for(8'd1, 8'd255));
    finish_op("g1_255", lat);
    check("g1_255 lat_const", 32'(lat), 32'(257));

    // Zero-operand shortcuts
    launch(8'd0, 8'd0, 1'b0, expect_for(8'd0, 8'd0));
    finish_op("g0_0", lat);
    launch(8'd0, 8'd45, 1'b0, expect_for(8'd0, 8'd45));
    finish_op("g0_45", lat);
    launch(8'd77, 8'd0, 1'b0, expect_for(8'd77, 8'd0));
    finish_op("g77_0", lat);

    // Equal operands and coprime pair
    launch(8'd255, 8'd255, 1'b0, expect_for(8'd255, 8'd255));
    finish_op("g255_255", lat);
    launch(8'd17, 8'd5, 1'b0, expect_for(8'd17, 8'd5));
    finish_op("g17_5", lat);

    // start held high through a whole operation on (36,24)
    launch(8'd36, 8'd24, 1'b1, expect_for(8'd36, 8'd24));
    finish_op("held36_24", lat);
    // Now in the IDLE cycle after done with start still high: accepted at the next edge
    sb.push_back(expect_for(8'd36, 8'd24));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_op("held_next", lat);

    // Reset asserted in RUN cycle 5 of (200,3)
    launch(8'd200, 8'd3, 1'b0, expect_for(8'd200, 8'd3));
    repeat (5) @(negedge clk);
    check("midrst busy_before", 32'(bus.busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(bus.busy), 32'(0));
    check("midrst done", 32'(bus.done), 32'(0));
    check("midrst result", 32'(bus.result), 32'(0));
    check("midrst alu_mod", 32'(bus.alu_mod), 32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
    end
    check("midrst no_done", 32'(spurious), 32'(0));
    launch(8'd9, 8'd6, 1'b0, expect_for(8'd9, 8'd6));
    finish_op("g9_6", lat);

`ifdef GCD_TIMEOUT_EN
    // Stuck unit: never reaches zero, aborts after 257 RUN cycles
    stuck = 1'b1;
    e.result = 8'd0;
    e.err    = 1'b1;
    e.lat    = 258;
    launch(8'd1, 8'd255, 1'b0, e);
    finish_op("timeout_stuck", lat);
    stuck = 1'b0;
    // Clean run after a timeout clears err
    launch(8'd12, 8'd8, 1'b0, expect_for(8'd12, 8'd8));
    finish_op("post_timeout", lat);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
